stream_demux: RTL and testbench



---
 rtl/stream_demux.sv | 133 +++++++++++++
 tb/tb_stream_demux.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : 1-to-CHANNELS valid/ready stream demultiplexer. Each output
//               channel owns a single registered slot (valid + data). Words
//               are steered by in_sel; out-of-range selects are accepted,
//               discarded and counted in a saturating drop counter.
//               Optional broadcast mode enabled by STREAM_DEMUX_BCAST_EN:
//               an in_bcast word is written to every slot at once.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]          drop_cnt
`ifdef STREAM_DEMUX_BCAST_EN
  ,
  input  logic                      in_bcast
`endif
);

  // One extra bit so the range compare also works when CHANNELS is a power of 2.
  localparam logic [SEL_W:0]   c_chan_lim = (SEL_W + 1)'(CHANNELS);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  logic [CHANNELS-1:0]       r_valid;
  logic [CHANNELS*WIDTH-1:0] r_data;
  logic [CNT_W-1:0]          r_drop;

  logic [CHANNELS-1:0] w_free;
  logic [CHANNELS-1:0] w_load;
  logic                w_in_range;
  logic                w_sel_free;
  logic                w_ready;
  logic                w_hs;
  logic                w_drop;
`ifdef STREAM_DEMUX_BCAST_EN
  logic                w_all_free;
`endif

  // Slot availability and selected-channel lookup (independent of in_data/in_valid).
  always_comb begin
    w_free     = ~r_valid | out_ready;
    w_in_range = ({1'b0, in_sel} < c_chan_lim);
    w_sel_free = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_sel_free = w_free[k];
      end
    end
`ifdef STREAM_DEMUX_BCAST_EN
    w_all_free = &w_free;
`endif
  end

  // Input acceptance: forced low in reset; out-of-range words are always taken.
  always_comb begin
    w_ready = 1'b0;
    if (!rst) begin
      if (w_in_range) begin
        w_ready = w_sel_free;
      end else begin
        w_ready = 1'b1;
      end
`ifdef STREAM_DEMUX_BCAST_EN
      if (in_bcast) begin
        w_ready = w_all_free;
      end
`endif
    end
  end

  // Per-channel load strobes and drop event for the current handshake.
  always_comb begin
    w_hs   = in_valid & w_ready;
    w_load = '0;
    w_drop = w_hs & ~w_in_range;
    for (int k = 0; k < CHANNELS; k++) begin
      w_load[k] = w_hs & w_in_range & (in_sel == SEL_W'(k));
    end
`ifdef STREAM_DEMUX_BCAST_EN
    if (in_bcast) begin
      w_load = {CHANNELS{w_hs}};
      w_drop = 1'b0;
    end
`endif
  end

  // Slot registers: a load takes priority over a drain; a drain keeps the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_load[k]) begin
          r_valid[k]                <= 1'b1;
          r_data[k*WIDTH +: WIDTH]  <= in_data;
        end else if (r_valid[k] && out_ready[k]) begin
          r_valid[k]                <= 1'b0;
        end
      end
    end
  end

  // Saturating count of words discarded for an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != c_cnt_max)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux
// Description : Randomised scoreboard bench. Two instances share one producer:
//               a 4-channel demux (CNT_W=8) and a 3-channel demux (CNT_W=2) so
//               that select 3 is routed on one and dropped on the other.
//               Broadcast traffic is generated when STREAM_DEMUX_BCAST_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_demux;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  sel;
  logic [W-1:0] data;
  logic        bc;
  logic        va, vb;
  logic        ra, rb;
  logic [3:0]  ordy;
  logic [3:0]  ova;
  logic [2:0]  ovb;
  logic [15:0] oda;
  logic [11:0] odb;
  logic [7:0]  dca;
  logic [1:0]  dcb;

  stream_demux #(.WIDTH(W), .CHANNELS(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_data(data),
    .in_sel(sel), .out_valid(ova), .out_ready(ordy), .out_data(oda),
    .drop_cnt(dca)
`ifdef STREAM_DEMUX_BCAST_EN
    , .in_bcast(bc)
`endif
  );

  stream_demux #(.WIDTH(W), .CHANNELS(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_data(data),
    .in_sel(sel), .out_valid(ovb), .out_ready(ordy[2:0]), .out_data(odb),
    .drop_cnt(dcb)
`ifdef STREAM_DEMUX_BCAST_EN
    , .in_bcast(bc)
`endif
  );

  // Reference model: per-instance, per-channel queue of words awaiting their consumer.
  logic [W-1:0] q    [2][4][$];
  logic [W-1:0] last [2][4];
  int           drops[2];
  bit           acc  [2];
  int           nch  [2] = '{4, 3};
  int           cmax [2] = '{255, 3};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit slot_free(input int d, input int k);
    return (q[d][k].size() == 0) || ordy[k];
  endfunction

  function automatic bit exp_ready(input int d);
    bit all_free;
    if (rst) return 1'b0;
    if (bc) begin
      all_free = 1'b1;
      for (int k = 0; k < nch[d]; k++) all_free &= slot_free(d, k);
      return all_free;
    end
    if (int'(sel) >= nch[d]) return 1'b1;
    return slot_free(d, int'(sel));
  endfunction

  function automatic int dut_valid(input int d, input int k);
    if (d == 0) return int'(ova[k]);
    return int'(ovb[k]);
  endfunction

  function automatic int dut_data(input int d, input int k);
    if (d == 0) return int'(oda[k*W +: W]);
    return int'(odb[k*W +: W]);
  endfunction

  // Expected-response generation at each active edge, from the model's own state.
  initial begin : model
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          for (int k = 0; k < 4; k++) begin
            q[d][k].delete();
            last[d][k] = '0;
          end
          drops[d] = 0;
          acc[d]   = 1'b0;
        end else begin
          acc[d] = ((d == 0) ? va : vb) && exp_ready(d);
          for (int k = 0; k < nch[d]; k++) begin
            if (q[d][k].size() != 0 && ordy[k]) void'(q[d][k].pop_front());
          end
          if (acc[d]) begin
            if (bc) begin
              for (int k = 0; k < nch[d]; k++) begin
                q[d][k].push_back(data);
                last[d][k] = data;
              end
            end else if (int'(sel) < nch[d]) begin
              q[d][int'(sel)].push_back(data);
              last[d][int'(sel)] = data;
            end else begin
              drops[d]++;
            end
          end
        end
      end
    end
  end

  // Monitor: compares every presented output against the scoreboard between edges.
  initial begin : monitor
    int exp_d;
    forever begin
      @(negedge clk);
      #1;
      chk("in_ready_a", int'(ra), int'(exp_ready(0)));
      chk("in_ready_b", int'(rb), int'(exp_ready(1)));
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < nch[d]; k++) begin
          chk($sformatf("out_valid[%0d] dut%0d", k, d), dut_valid(d, k),
              (q[d][k].size() != 0) ? 1 : 0);
          exp_d = (q[d][k].size() != 0) ? int'(q[d][k][0]) : int'(last[d][k]);
          chk($sformatf("out_data[%0d] dut%0d", k, d), dut_data(d, k), exp_d);
        end
      end
      chk("drop_cnt_a", int'(dca), (drops[0] > cmax[0]) ? cmax[0] : drops[0]);
      chk("drop_cnt_b", int'(dcb), (drops[1] > cmax[1]) ? cmax[1] : drops[1]);
    end
  end

  // Producer and consumers: words are held until each instance accepts them.
  initial begin : stim
    rst = 1'b1; va = 1'b0; vb = 1'b0; sel = '0; data = '0; bc = 1'b0; ordy = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || (cyc == 1500) || (cyc == 1501);
      if (acc[0]) va = 1'b0;
      if (acc[1]) vb = 1'b0;
      if (rst) begin
        va = 1'b0;
        vb = 1'b0;
      end else if (!va && !vb && ($urandom_range(3) != 0)) begin
        data = W'($urandom);
        sel  = 2'($urandom);
`ifdef STREAM_DEMUX_BCAST_EN
        bc   = ($urandom_range(7) == 0);
`endif
        va   = 1'b1;
        vb   = 1'b1;
      end
      if (cyc < 1000)      ordy = 4'($urandom);
      else if (cyc < 2000) ordy = 4'($urandom & $urandom);
      else                 ordy = 4'($urandom | $urandom);
    end
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
